// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock frequency monitor: per-channel FSM
// states, synchroniser depth and the bad-window streak counter width.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } mon_state_t;

  // Flops between the asynchronous monitored clock and the edge detector.
  localparam int SYNC_STAGES = 2;

  // Width of the consecutive-bad-window counter (FAIL_CNT is 1..15).
  localparam int FCW = 4;

endpackage

// File: rtl/clk_mon_ch.sv
// One monitored-clock channel: synchroniser, saturating edge counter,
// window compare, bad-window streak, channel FSM and sticky fault flop.
// Build option: CLK_MON_OVERFREQ_EN adds the upper (hi_th) compare; without
// it only under-frequency is judged and hi_th is left unconnected inside.
module clk_mon_ch
  import clk_mon_pkg::*;
#(
  parameter int CW       = 9,
  parameter int FAIL_CNT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mon_clk,
  input  logic          en,
  input  logic [CW-1:0] lo_th,
  input  logic [CW-1:0] hi_th,
  input  logic          clr,
  input  logic          win_end,
  output logic [CW-1:0] cnt_out,
  output logic          fault,
  output mon_state_t    state
);

  localparam logic [CW-1:0]  CNT_MAX = '1;
  localparam logic [FCW-1:0] STK_MAX = '1;
  localparam logic [FCW-1:0] FAIL_TH = FCW'(FAIL_CNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic [CW-1:0]          edge_q;
  logic [CW-1:0]          total;
  logic                   bad;
  logic [FCW-1:0]         streak_q;
  logic [FCW-1:0]         streak_inc;
  logic                   fault_q;
  mon_state_t             state_q;
  mon_state_t             state_d;

  // Bring mon_clk into the clk domain and keep one history bit for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Running total including an edge seen this cycle, saturating at all-ones.
  always_comb begin
    total = edge_q;
    if (rise && (edge_q != CNT_MAX)) total = edge_q + CW'(1);
  end

`ifdef CLK_MON_OVERFREQ_EN
  // Window is bad when the edge total falls outside [lo_th, hi_th].
  always_comb begin
    bad = (total < lo_th) || (total > hi_th);
  end
`else
  logic unused_hi_th;
  assign unused_hi_th = ^hi_th;

  // Window is bad when the edge total is below lo_th.
  always_comb begin
    bad = (total < lo_th);
  end
`endif

  assign streak_inc = (streak_q == STK_MAX) ? streak_q : streak_q + FCW'(1);

  // Channel FSM next state; FAULT is sticky and only clr leaves it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (en) state_d = ARM;
      ARM: begin
        if (!en)          state_d = IDLE;
        else if (win_end) state_d = RUN;
      end
      RUN: begin
        if (!en) state_d = IDLE;
        else if (win_end && bad && (streak_inc >= FAIL_TH)) state_d = FAULT;
      end
      FAULT: if (clr) state_d = en ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, edge counter, latched window count, streak and fault registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      edge_q   <= '0;
      cnt_out  <= '0;
      streak_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= (state_d == FAULT);

      if (state_q == IDLE || win_end) edge_q <= '0;
      else                            edge_q <= total;

      if (win_end) cnt_out <= (state_q == IDLE) ? '0 : total;

      if (state_q != RUN)  streak_q <= '0;
      else if (win_end)    streak_q <= bad ? streak_inc : '0;
    end
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: rtl/clk_mon_n.sv
// N-channel clock frequency monitor top: shared free-running window counter,
// per-channel monitors, count-valid pulse, fault OR and fail-safe reset.
// Build option: CLK_MON_OVERFREQ_EN enables the over-frequency (hi_th) check.
// cnt_vld is a one-cycle valid pulse with no ready: the consumer must take
// cnt_out in the cycle cnt_vld is high; there is no backpressure.
module clk_mon_n
  import clk_mon_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CW       = 9,
  parameter int WIN_LOG2 = 8,
  parameter int FAIL_CNT = 2,
  parameter int SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    mon_clk,
  input  logic [NCH-1:0]    en,
  input  logic [NCH*CW-1:0] lo_th,
  input  logic [NCH*CW-1:0] hi_th,
  input  logic [NCH-1:0]    clr,
  input  logic [SELW-1:0]   sel,
  output logic [NCH*CW-1:0] cnt_out,
  output logic              cnt_vld,
  output logic [NCH-1:0]    fault,
  output logic              fault_irq,
  output logic              fs_rst_n
);

  logic [WIN_LOG2-1:0] win_q;
  logic                win_end;
  logic                fault_sel;

  // Per-channel FSM state, kept visible for probing; not used by logic here.
  mon_state_t          dbg_state_unused [NCH];

  // Free-running window counter shared by every channel.
  always_ff @(posedge clk) begin
    if (!rst_n) win_q <= '0;
    else        win_q <= win_q + WIN_LOG2'(1);
  end

  assign win_end = &win_q;

  // cnt_out is latched on the window-end edge, so flag it one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_vld <= 1'b0;
    else        cnt_vld <= win_end;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_mon_ch #(
      .CW       (CW),
      .FAIL_CNT (FAIL_CNT)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .mon_clk (mon_clk[i]),
      .en      (en[i]),
      .lo_th   (lo_th[i*CW +: CW]),
      .hi_th   (hi_th[i*CW +: CW]),
      .clr     (clr[i]),
      .win_end (win_end),
      .cnt_out (cnt_out[i*CW +: CW]),
      .fault   (fault[i]),
      .state   (dbg_state_unused[i])
    );
  end

  assign fault_irq = |fault;

  // An out-of-range sel never selects a faulted channel.
  assign fault_sel = (32'(sel) < NCH) ? fault[sel] : 1'b0;

  // Fail-safe reset for the clock currently in use, registered.
  always_ff @(posedge clk) begin
    if (!rst_n) fs_rst_n <= 1'b1;
    else        fs_rst_n <= ~fault_sel;
  end

endmodule

// File: tb/tb_clk_mon_n.sv
// Self-checking bench for clk_mon_n (NCH=2, CW=9, WIN_LOG2=8, FAIL_CNT=2).
// Monitored clocks are produced on clk negedges so that every edge has a
// well-defined sampling cycle, which lets the reference model predict exact
// window counts. Build with CLK_MON_OVERFREQ_EN to exercise the hi_th check.
module tb_clk_mon_n;

  localparam int NCH  = 2;
  localparam int CW   = 9;
  localparam int WIN  = 256;
  localparam int FAIL = 2;
  localparam int LO   = 12;
  localparam int HI   = 20;
  localparam int W    = NCH * CW;

  localparam int M_ARM = 0;
  localparam int M_RUN = 1;
  localparam int M_FLT = 2;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    mon_clk;
  logic [NCH-1:0]    en;
  logic [NCH*CW-1:0] lo_th;
  logic [NCH*CW-1:0] hi_th;
  logic [NCH-1:0]    clr;
  logic [0:0]        sel;
  logic [NCH*CW-1:0] cnt_out;
  logic              cnt_vld;
  logic [NCH-1:0]    fault;
  logic              fault_irq;
  logic              fs_rst_n;

  clk_mon_n #(
    .NCH      (NCH),
    .CW       (CW),
    .WIN_LOG2 (8),
    .FAIL_CNT (FAIL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mon_clk   (mon_clk),
    .en        (en),
    .lo_th     (lo_th),
    .hi_th     (hi_th),
    .clr       (clr),
    .sel       (sel),
    .cnt_out   (cnt_out),
    .cnt_vld   (cnt_vld),
    .fault     (fault),
    .fault_irq (fault_irq),
    .fs_rst_n  (fs_rst_n)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #4 clk = ~clk;

  // ---------------- monitored clock generator ----------------
  // mode 0: stopped, 1: ~8 MHz with random half-period 7..9, 2: 32 MHz.
  int mode [NCH];
  int ph   [NCH];

  initial begin
    mon_clk = '0;
    for (int i = 0; i < NCH; i++) ph[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (mode[i] == 0) begin
        mon_clk[i] = 1'b0;
        ph[i] = 0;
      end else if (ph[i] == 0) begin
        mon_clk[i] = ~mon_clk[i];
        ph[i] = ((mode[i] == 1) ? int'($urandom_range(7, 9)) : 2) - 1;
      end else begin
        ph[i] = ph[i] - 1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Counts clk cycles since reset; windows complete every 256 cycles. An edge
  // first sampled at cycle q lands in the window that completes at the first
  // multiple of 256 that is >= q+2.
  int             n;
  logic [NCH-1:0] prev;
  int             wcnt   [NCH][2];
  int             mphase [NCH];
  int             streak [NCH];
  int             mc     [NCH];
  logic [NCH-1:0] fault_m;
  logic           fs_m;
  logic           vld_m;
  logic           started;
  logic           mbad;
  logic           mwe;
  logic [W-1:0]   exp_q [$];

  initial started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0;
      prev = '0;
      for (int i = 0; i < NCH; i++) begin
        wcnt[i][0] = 0;
        wcnt[i][1] = 0;
        mphase[i]  = M_ARM;
        streak[i]  = 0;
      end
      fault_m = '0;
      fs_m    = 1'b1;
      vld_m   = 1'b0;
      exp_q.delete();
      started = 1'b1;
    end else begin
      fs_m = !fault_m[sel];
      n = n + 1;
      mwe = ((n % WIN) == 0);
      for (int i = 0; i < NCH; i++) begin
        if (mon_clk[i] && !prev[i]) wcnt[i][((n + 2 + WIN - 1) / WIN) % 2]++;
        mc[i] = 0;
        if (mwe) begin
          mc[i] = (wcnt[i][(n / WIN) % 2] > 511) ? 511 : wcnt[i][(n / WIN) % 2];
          wcnt[i][(n / WIN) % 2] = 0;
        end
      end
      prev = mon_clk;
      for (int i = 0; i < NCH; i++) begin
        if (mphase[i] == M_FLT && clr[i]) begin
          mphase[i] = M_ARM;
          streak[i] = 0;
        end else if (mwe) begin
          if (mphase[i] == M_ARM) begin
            mphase[i] = M_RUN;
            streak[i] = 0;
          end else if (mphase[i] == M_RUN) begin
`ifdef CLK_MON_OVERFREQ_EN
            mbad = (mc[i] < LO) || (mc[i] > HI);
`else
            mbad = (mc[i] < LO);
`endif
            streak[i] = mbad ? streak[i] + 1 : 0;
            if (streak[i] >= FAIL) mphase[i] = M_FLT;
          end
        end
        fault_m[i] = (mphase[i] == M_FLT);
      end
      if (mwe) exp_q.push_back({9'(mc[1]), 9'(mc[0])});
      vld_m = mwe;
    end
  end

  // ---------------- scoreboard helpers ----------------
  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (((n % WIN) != p) && (k < 1000));
    if ((n % WIN) != p) chk("wait_phase_timeout", 32'(k), 32'(0));
  endtask

  task automatic pulse_clr(input logic [NCH-1:0] v);
    clr = v;
    @(negedge clk);
    clr = '0;
  endtask

  // ---------------- stimulus + monitor ----------------
  logic [W-1:0] e;

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    en      = '1;
    clr     = '0;
    sel     = 1'b0;
    lo_th   = {9'(LO), 9'(LO)};
    hi_th   = {9'(HI), 9'(HI)};
    mode[0] = 1;
    mode[1] = 2;

    fork
      begin : stim
        repeat (3) @(negedge clk);
        chk("reset_cnt_out", 32'(cnt_out), 32'(0));
        chk("reset_fs_rst_n", 32'(fs_rst_n), 32'(1));
        rst_n = 1'b1;

        // Good clock: first window discarded, later windows judged good.
        repeat (4) wait_phase(10);
        chk("good_no_fault0", 32'(fault[0]), 32'(0));

        // Single bad window then recovery: streak resets.
        wait_phase(5);
        mode[0] = 0;
        repeat (240) @(negedge clk);
        mode[0] = 1;
        repeat (3) wait_phase(10);
        chk("single_bad_no_fault0", 32'(fault[0]), 32'(0));

        // Point sel at channel 1 briefly (faulted only with over-freq check).
        sel = 1'b1;
        repeat (20) @(negedge clk);
        sel = 1'b0;
        repeat (3) @(negedge clk);

        // Clock loss with clr on both window ends: set wins on the second.
        wait_phase(5);
        mode[0] = 0;
        repeat (2) begin
          wait_phase(WIN - 1);
          pulse_clr(2'b01);
        end
        chk("clr_coincident_fault0", 32'(fault[0]), 32'(1));
        repeat (2) @(negedge clk);
        chk("loss_fs_rst_n_low", 32'(fs_rst_n), 32'(0));
        repeat (30) @(negedge clk);
        clr = 2'b01;
        @(negedge clk);
        clr = '0;
        chk("clr_alone_fault0", 32'(fault[0]), 32'(0));
        @(negedge clk);
        chk("clr_alone_fs_rst_n", 32'(fs_rst_n), 32'(1));
        mode[0] = 1;
        repeat (3) wait_phase(10);

        // Reset mid-window.
        wait_phase(100);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_cnt_out", 32'(cnt_out), 32'(0));
        chk("midrst_cnt_vld", 32'(cnt_vld), 32'(0));
        chk("midrst_fault", 32'(fault), 32'(0));
        chk("midrst_fault_irq", 32'(fault_irq), 32'(0));
        chk("midrst_fs_rst_n", 32'(fs_rst_n), 32'(1));
        rst_n = 1'b1;
        repeat (3) wait_phase(10);

        // Randomised traffic: clock drop-outs, clears and sel changes.
        repeat (10) begin
          wait_phase(int'($urandom_range(1, 250)));
          mode[0] = int'($urandom_range(0, 1));
          sel = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 2) == 0) pulse_clr(2'($urandom_range(1, 3)));
        end
        mode[0] = 1;
        sel = 1'b0;
        repeat (2) wait_phase(10);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
      end

      begin : mon
        forever begin
          @(negedge clk);
          if (started) begin
            chk("cnt_vld", 32'(cnt_vld), 32'(vld_m));
            if (cnt_vld === 1'b1) begin
              if (exp_q.size() == 0) begin
                chk("cnt_vld_unexpected", 32'(1), 32'(0));
              end else begin
                e = exp_q.pop_front();
                chk("cnt_out", 32'(cnt_out), 32'(e));
              end
            end
            chk("fault", 32'(fault), 32'(fault_m));
            chk("fault_irq", 32'(fault_irq), 32'(|fault_m));
            chk("fs_rst_n", 32'(fs_rst_n), 32'(fs_m));
          end
        end
      end
    join_any

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
